// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: EX-stage hazard controller for a 5-stage pipeline.
// Tracks the EX/MEM/WB occupants and produces ALU operand forwarding
// selects, load-use stall/bubble and a saturating stall counter.
// Optional feature: define EX_HAZARD_FORWARDING_EN to enable operand
// forwarding; when undefined, every RAW hazard against EX or MEM stalls.
module ex_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rm,
  input  logic        id_rm_used,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  output logic [1:0]  forwardA,
  output logic [1:0]  forwardB,
  output logic        stall,
  output logic        bubble,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [4:0] XZR     = 5'd31;

  // Stage shadows: destination register, write-enable and load flag.
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       ex_wr, mem_wr, wb_wr;
  logic       ex_ld, mem_ld, wb_ld;

  logic       ex_hit_rn, ex_hit_rm, mem_hit_rn, mem_hit_rm;
  logic       hazard;
  logic [1:0] fwd_a_nxt, fwd_b_nxt;
  logic       wb_unused;

  // A stage supplies register r only if it writes it and r is not XZR.
  function automatic logic stage_match(input logic wr, input logic [4:0] rd,
                                       input logic [4:0] r);
    return wr && (rd == r) && (rd != XZR);
  endfunction

  // The WB occupant never drives a decision: the register file is
  // write-through, so an instruction reading in ID already sees WB data.
  assign wb_unused = ^{wb_rd, wb_wr, wb_ld};

  // Register-match terms of the ID instruction against EX and MEM.
  always_comb begin
    ex_hit_rn  = stage_match(ex_wr, ex_rd, id_rn);
    mem_hit_rn = stage_match(mem_wr, mem_rd, id_rn);
    if (id_rm_used) begin
      ex_hit_rm  = stage_match(ex_wr, ex_rd, id_rm);
      mem_hit_rm = stage_match(mem_wr, mem_rd, id_rm);
    end else begin
      ex_hit_rm  = 1'b0;
      mem_hit_rm = 1'b0;
    end
  end

`ifdef EX_HAZARD_FORWARDING_EN
  // Forwarding build: only a load in EX forces a stall; other RAW
  // dependencies are satisfied by the forwarding selects.
  always_comb begin
    hazard = id_valid && ex_ld && (ex_hit_rn || ex_hit_rm);
  end

  // Next ALU operand selects; EX/MEM result wins over the WB value.
  always_comb begin
    fwd_a_nxt = FWD_RF;
    fwd_b_nxt = FWD_RF;
    if (bubble) begin
      fwd_a_nxt = FWD_RF;
      fwd_b_nxt = FWD_RF;
    end else begin
      if (ex_hit_rn) begin
        fwd_a_nxt = FWD_MEM;
      end else if (mem_hit_rn) begin
        fwd_a_nxt = FWD_WB;
      end else begin
        fwd_a_nxt = FWD_RF;
      end
      if (ex_hit_rm) begin
        fwd_b_nxt = FWD_MEM;
      end else if (mem_hit_rm) begin
        fwd_b_nxt = FWD_WB;
      end else begin
        fwd_b_nxt = FWD_RF;
      end
    end
  end
`else
  // Non-forwarding build: any dependency on EX or MEM stalls until the
  // producer has reached WB and the write-through register file.
  always_comb begin
    hazard = id_valid && (ex_hit_rn || ex_hit_rm || mem_hit_rn || mem_hit_rm);
  end

  // Operands always come from the register file.
  always_comb begin
    fwd_a_nxt = FWD_RF;
    fwd_b_nxt = FWD_RF;
  end
`endif

  // Stall and bubble are the same signal and are killed by reset at once.
  always_comb begin
    if (reset) begin
      stall = 1'b0;
    end else begin
      stall = hazard;
    end
    bubble = stall;
  end

  // Advance the stage shadows every clock; a bubble enters EX as a no-op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_rd  <= 5'd0;  ex_wr  <= 1'b0; ex_ld  <= 1'b0;
      mem_rd <= 5'd0;  mem_wr <= 1'b0; mem_ld <= 1'b0;
      wb_rd  <= 5'd0;  wb_wr  <= 1'b0; wb_ld  <= 1'b0;
    end else begin
      wb_rd  <= mem_rd; wb_wr  <= mem_wr; wb_ld  <= mem_ld;
      mem_rd <= ex_rd;  mem_wr <= ex_wr;  mem_ld <= ex_ld;
      ex_rd  <= id_rd;
      if (bubble) begin
        ex_wr <= 1'b0;
        ex_ld <= 1'b0;
      end else begin
        ex_wr <= id_reg_write & id_valid;
        ex_ld <= id_mem_read & id_valid;
      end
    end
  end

  // Register the operand selects on the edge the instruction enters EX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      forwardA <= FWD_RF;
      forwardB <= FWD_RF;
    end else begin
      forwardA <= fwd_a_nxt;
      forwardB <= fwd_b_nxt;
    end
  end

  // Count stall cycles, holding at the maximum value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl. Expected per-instruction results
// are queued when the instruction is presented and compared when the DUT
// registers them. Covers the build selected by EX_HAZARD_FORWARDING_EN.
module tb_ex_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic        id_rm_used, id_reg_write, id_mem_read;
  logic [1:0]  forwardA, forwardB;
  logic        stall, bubble;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic        st;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_cnt;

  ex_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn),
    .id_rm(id_rm), .id_rm_used(id_rm_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .forwardA(forwardA), .forwardB(forwardB), .stall(stall),
    .bubble(bubble), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                        input logic used, input logic [4:0] rd, input logic wr,
                        input logic ld);
    id_valid = v; id_rn = rn; id_rm = rm; id_rm_used = used;
    id_rd = rd; id_reg_write = wr; id_mem_read = ld;
  endtask

  // Present one instruction for one cycle and score it.
  task automatic step(input string tag, input logic v, input logic [4:0] rn,
                      input logic [4:0] rm, input logic used, input logic [4:0] rd,
                      input logic wr, input logic ld, input logic est,
                      input logic [1:0] efa, input logic [1:0] efb);
    exp_t e;
    @(negedge clk);
    set_in(v, rn, rm, used, rd, wr, ld);
    if (est && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    e.tag = tag; e.st = est; e.fa = efa; e.fb = efb; e.cnt = exp_cnt;
    sb.push_back(e);
    #2;
    check_eq({tag, ".stall"},  16'(stall),  16'(sb[0].st));
    check_eq({tag, ".bubble"}, 16'(bubble), 16'(sb[0].st));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq({e.tag, ".fwdA"}, 16'(forwardA), 16'(e.fa));
    check_eq({e.tag, ".fwdB"}, 16'(forwardB), 16'(e.fb));
    check_eq({e.tag, ".cnt"},  stall_cnt,     e.cnt);
  endtask

  task automatic nop();
    step("nop", 1'b0, 5'd31, 5'd31, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    set_in(1'b0, 5'd31, 5'd31, 1'b0, 5'd31, 1'b0, 1'b0);
    #2;
    check_eq("rst.stall",  16'(stall),  16'd0);
    check_eq("rst.bubble", 16'(bubble), 16'd0);
    @(posedge clk);
    #1;
    check_eq("rst.fwdA", 16'(forwardA), 16'd0);
    check_eq("rst.fwdB", 16'(forwardB), 16'd0);
    check_eq("rst.cnt",  stall_cnt,     16'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 16'd0;
    sb.delete();
  endtask

  // Reset while a stall is being asserted; outputs must clear at once.
  task automatic reset_mid_stall(input string tag);
    #2;
    check_eq({tag, ".pre_stall"}, 16'(stall), 16'd1);
    reset = 1'b1;
    #1;
    check_eq({tag, ".stall"},  16'(stall),     16'd0);
    check_eq({tag, ".bubble"}, 16'(bubble),    16'd0);
    check_eq({tag, ".fwdA"},   16'(forwardA),  16'd0);
    check_eq({tag, ".fwdB"},   16'(forwardB),  16'd0);
    check_eq({tag, ".cnt"},    stall_cnt,      16'd0);
    @(negedge clk);
    reset = 1'b0;
    set_in(1'b0, 5'd31, 5'd31, 1'b0, 5'd31, 1'b0, 1'b0);
    exp_cnt = 16'd0;
  endtask

  initial begin
    reset = 1'b1;
    exp_cnt = 16'd0;
    set_in(1'b0, 5'd31, 5'd31, 1'b0, 5'd31, 1'b0, 1'b0);
    reset_dut();

`ifdef EX_HAZARD_FORWARDING_EN
    // ADD X1 ; ADD X2,X1,X3
    step("add_x1",   1, 5'd2, 5'd3, 1, 5'd1, 1, 0, 0, 2'b00, 2'b00);
    step("add_x2",   1, 5'd1, 5'd3, 1, 5'd2, 1, 0, 0, 2'b10, 2'b00);
    nop(); nop();
    // ADD X1 ; NOP ; SUB X4,X1,X1
    step("add_x1b",  1, 5'd9, 5'd10, 1, 5'd1, 1, 0, 0, 2'b00, 2'b00);
    nop();
    step("sub_x4",   1, 5'd1, 5'd1, 1, 5'd4, 1, 0, 0, 2'b01, 2'b01);
    nop(); nop();
    // Two producers of X1: the younger (EX/MEM) wins
    step("add_x1c",  1, 5'd2, 5'd3, 1, 5'd1, 1, 0, 0, 2'b00, 2'b00);
    step("add_x1d",  1, 5'd2, 5'd3, 1, 5'd1, 1, 0, 0, 2'b00, 2'b00);
    step("prio",     1, 5'd1, 5'd1, 1, 5'd2, 1, 0, 0, 2'b10, 2'b10);
    nop(); nop();
    // LDUR X5 ; ADD X6,X5,X7: one stall, then WB forward
    step("ldur_x5",  1, 5'd20, 5'd31, 0, 5'd5, 1, 1, 0, 2'b00, 2'b00);
    step("lu_stall", 1, 5'd5, 5'd7, 1, 5'd6, 1, 0, 1, 2'b00, 2'b00);
    step("lu_go",    1, 5'd5, 5'd7, 1, 5'd6, 1, 0, 0, 2'b01, 2'b00);
    nop(); nop();
    // Load-use through the second operand
    step("ldur_x5b", 1, 5'd20, 5'd31, 0, 5'd5, 1, 1, 0, 2'b00, 2'b00);
    step("lurm_st",  1, 5'd8, 5'd5, 1, 5'd9, 1, 0, 1, 2'b00, 2'b00);
    step("lurm_go",  1, 5'd8, 5'd5, 1, 5'd9, 1, 0, 0, 2'b00, 2'b01);
    nop(); nop();
    // Load followed by immediate form whose rm field aliases the load
    step("ldur_x5c", 1, 5'd20, 5'd31, 0, 5'd5, 1, 1, 0, 2'b00, 2'b00);
    step("imm_nost", 1, 5'd8, 5'd5, 0, 5'd9, 1, 0, 0, 2'b00, 2'b00);
    nop(); nop();
    // Invalid ID slot after a load never stalls
    step("ldur_x5d", 1, 5'd20, 5'd31, 0, 5'd5, 1, 1, 0, 2'b00, 2'b00);
    step("inval",    0, 5'd5, 5'd5, 1, 5'd6, 1, 0, 0, 2'b10, 2'b10);
    nop(); nop();
    // XZR producer/consumer
    step("prod_x31", 1, 5'd2, 5'd3, 1, 5'd31, 1, 0, 0, 2'b00, 2'b00);
    step("cons_x31", 1, 5'd31, 5'd31, 1, 5'd8, 1, 0, 0, 2'b00, 2'b00);
    step("ld_x31",   1, 5'd2, 5'd31, 0, 5'd31, 1, 1, 0, 2'b00, 2'b00);
    step("cons_l31", 1, 5'd31, 5'd31, 1, 5'd9, 1, 0, 0, 2'b00, 2'b00);
    nop(); nop();
    // ADD X1 ; ADDI X8,X1,#4
    step("add_x1e",  1, 5'd2, 5'd3, 1, 5'd1, 1, 0, 0, 2'b00, 2'b00);
    step("addi_x8",  1, 5'd1, 5'd1, 0, 5'd8, 1, 0, 0, 2'b10, 2'b00);
    nop(); nop();
    // Reset during a load-use stall
    step("ldur_x5e", 1, 5'd20, 5'd31, 0, 5'd5, 1, 1, 0, 2'b00, 2'b00);
    @(negedge clk);
    set_in(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0);
    reset_mid_stall("rst_mid");
`else
    // ADD X1 ; ADD X2,X1,X3: two stall cycles, no forwarding
    step("add_x1",   1, 5'd2, 5'd3, 1, 5'd1, 1, 0, 0, 2'b00, 2'b00);
    step("cons_st1", 1, 5'd1, 5'd3, 1, 5'd2, 1, 0, 1, 2'b00, 2'b00);
    step("cons_st2", 1, 5'd1, 5'd3, 1, 5'd2, 1, 0, 1, 2'b00, 2'b00);
    step("cons_go",  1, 5'd1, 5'd3, 1, 5'd2, 1, 0, 0, 2'b00, 2'b00);
    nop(); nop();
    // Loads stall the same way
    step("ldur_x5",  1, 5'd20, 5'd31, 0, 5'd5, 1, 1, 0, 2'b00, 2'b00);
    step("ld_st1",   1, 5'd5, 5'd7, 1, 5'd6, 1, 0, 1, 2'b00, 2'b00);
    step("ld_st2",   1, 5'd5, 5'd7, 1, 5'd6, 1, 0, 1, 2'b00, 2'b00);
    step("ld_go",    1, 5'd5, 5'd7, 1, 5'd6, 1, 0, 0, 2'b00, 2'b00);
    nop(); nop();
    // Producer in MEM: one stall
    step("add_x1b",  1, 5'd2, 5'd3, 1, 5'd1, 1, 0, 0, 2'b00, 2'b00);
    nop();
    step("mem_st",   1, 5'd1, 5'd3, 1, 5'd2, 1, 0, 1, 2'b00, 2'b00);
    step("mem_go",   1, 5'd1, 5'd3, 1, 5'd2, 1, 0, 0, 2'b00, 2'b00);
    nop(); nop();
    // Producer in WB: no hazard
    step("add_x1c",  1, 5'd2, 5'd3, 1, 5'd1, 1, 0, 0, 2'b00, 2'b00);
    nop(); nop();
    step("wb_nost",  1, 5'd1, 5'd1, 1, 5'd2, 1, 0, 0, 2'b00, 2'b00);
    nop(); nop();
    // Second operand dependency, and immediate form ignoring rm
    step("add_x1d",  1, 5'd2, 5'd3, 1, 5'd1, 1, 0, 0, 2'b00, 2'b00);
    step("imm_nost", 1, 5'd2, 5'd1, 0, 5'd8, 1, 0, 0, 2'b00, 2'b00);
    step("rm_st",    1, 5'd2, 5'd1, 1, 5'd9, 1, 0, 1, 2'b00, 2'b00);
    step("rm_go",    1, 5'd2, 5'd1, 1, 5'd9, 1, 0, 0, 2'b00, 2'b00);
    nop(); nop();
    // XZR and invalid slots
    step("prod_x31", 1, 5'd2, 5'd3, 1, 5'd31, 1, 0, 0, 2'b00, 2'b00);
    step("cons_x31", 1, 5'd31, 5'd31, 1, 5'd8, 1, 0, 0, 2'b00, 2'b00);
    step("add_x1e",  1, 5'd2, 5'd3, 1, 5'd1, 1, 0, 0, 2'b00, 2'b00);
    step("inval",    0, 5'd1, 5'd1, 1, 5'd6, 1, 0, 0, 2'b00, 2'b00);
    nop(); nop();

    // Saturation: ADD X1,X1,X1 held in ID stalls 2 of every 3 cycles.
    reset_dut();
    @(negedge clk);
    set_in(1'b1, 5'd1, 5'd1, 1'b1, 5'd1, 1'b1, 1'b0);
    repeat (300) @(posedge clk);
    #1;
    check_eq("sat.cnt200", stall_cnt, 16'd200);
    repeat (98010) @(posedge clk);
    #1;
    check_eq("sat.cnt_max", stall_cnt, 16'hFFFF);
    check_eq("sat.fwdA", 16'(forwardA), 16'd0);
    @(posedge clk);
    #1;
    check_eq("sat.hold", stall_cnt, 16'hFFFF);
    reset_mid_stall("rst_mid");
`endif

    // The DUT is usable again after the mid-stall reset
    step("post_rst", 1, 5'd2, 5'd3, 1, 5'd1, 1, 0, 0, 2'b00, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_hazard_ctrl.md
EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 id_valid  input  1  ID stage holds a valid instruction.
REQ-005 id_rn  input  5  first source register of the ID instruction (feeds ALU input 1).
REQ-006 id_rm  input  5  second source register of the ID instruction.
REQ-007 id_rm_used  input  1  ALU input 2 comes from id_rm (0 = immediate via ALUSrc).
REQ-008 id_rd  input  5  destination register of the ID instruction.
REQ-009 id_reg_write  input  1  ID instruction writes id_rd.
REQ-010 id_mem_read  input  1  ID instruction is a load.
REQ-011 forwardA  output  2  ALU input 1 select, registered: 00 regfile, 10 EX/MEM result, 01 WB value.
REQ-012 forwardB  output  2  ALU input 2 select, registered, same encoding.
REQ-013 stall  output  1  combinational: hold PC and IF/ID this cycle.
REQ-014 bubble  output  1  combinational: load zeroed control into ID/EX this cycle; always equals stall.
REQ-015 stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-016 SHALL track EX, MEM and WB stage occupants, each holding rd[4:0], wr and ld bits, advanced every clock with no enable.
REQ-017 Each edge: MEM<=EX, WB<=MEM; EX<={id_rd, id_reg_write&id_valid, id_mem_read&id_valid}, or wr=ld=0 when bubble=1.
REQ-018 A stage matches register r when wr=1, rd==r and rd!=31; register 31 (XZR) never matches.
REQ-019 Load-use hazard = id_valid & EX.ld & (EX matches id_rn | (id_rm_used & EX matches id_rm)); stall=bubble=1 while true.
REQ-020 Next forwardA: 00 if bubble; else 10 if EX matches id_rn; else 01 if MEM matches id_rn; else 00.
REQ-021 Next forwardB: as REQ-020 using id_rm, and 00 whenever id_rm_used=0 so immediates are never overridden.
REQ-022 EX/MEM match SHALL take priority over the WB match when both hit.
REQ-023 forwardA/forwardB SHALL be registered on the edge the instruction enters EX, giving zero added latency.
REQ-024 After a one-cycle load-use stall the load sits in MEM; the re-presented instruction SHALL receive 01 (WB forward).
REQ-025 WB-stage writes are not hazards; the register file is write-through.
REQ-026 stall_cnt SHALL increment on every clock where stall=1 and hold at 16'hFFFF.
REQ-027 id_valid=0 SHALL never assert stall and SHALL still advance the stage shadows.

Reset
REQ-028 While reset=1: EX/MEM/WB wr=ld=0, rd=0; forwardA=forwardB=00; stall_cnt=0; stall=bubble=0.
REQ-029 Reset asserted mid-stall SHALL drop stall in the same cycle; no pending hazard survives reset.

Configuration
REQ-030 Macro EX_HAZARD_FORWARDING_EN defined: behaviour as REQ-019..REQ-024.
REQ-031 Macro undefined: forwardA=forwardB=00 constantly; stall=1 while id_valid and EX or MEM matches id_rn (or id_rm when id_rm_used), loads included; stall_cnt unchanged in function.

Verification
REQ-032 ADD X1 then ADD X2,X1,X3 back-to-back, forwarding on -> forwardA=10 on the consumer's EX cycle, stall=0 throughout.
REQ-033 ADD X1, NOP, SUB X4,X1,X1 -> forwardA=01, forwardB=01 on SUB's EX cycle.
REQ-034 LDUR X5 then ADD X6,X5,X7 -> stall=bubble=1 for exactly one cycle, then forwardA=01, stall_cnt=1.
REQ-035 Producer rd=31 followed by consumer rn=31 -> forwardA=00, no stall; ADDI X8,X1,#4 after ADD X1 -> forwardB=00, forwardA=10.
REQ-036 Forwarding macro off, ADD X1 then ADD X2,X1,X3 -> stall=1 for two cycles, forwards 00; 70000 forced stalls -> stall_cnt=16'hFFFF; reset mid-stall -> all outputs 0 immediately.
